// File: rtl/phy_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_serializer_pkg
// Shared PHY definitions used by the transmit serializer and the receive side:
//   COMMA_DEFAULT          - idle / sync word sent during preamble and idle slots
//   PREAMBLE_WORDS_DEFAULT - number of comma words sent after reset
//   NUM_LANES              - number of parallel serial lanes
//   tx_state_t             - serializer FSM state encoding
// -----------------------------------------------------------------------------
package phy_tx_serializer_pkg;

  localparam logic [7:0] COMMA_DEFAULT          = 8'hBC;
  localparam int         PREAMBLE_WORDS_DEFAULT = 4;
  localparam int         NUM_LANES              = 2;

  typedef enum logic {
    ST_PREAMBLE = 1'b0,
    ST_ACTIVE   = 1'b1
  } tx_state_t;

endpackage

// File: rtl/phy_tx_lane.sv
// -----------------------------------------------------------------------------
// phy_tx_lane
// One serial lane: 8-bit shift register plus the word-boundary load mux.
// Ports:
//   clk      - bit-rate clock
//   rst      - asynchronous active-high reset (register returns to COMMA)
//   advance  - 1 = shift/load this cycle, 0 = hold
//   boundary - current bit is the last of the word; load instead of shift
//   take     - at a boundary, load data (1) or COMMA (0)
//   data     - parallel byte to load
//   out      - serial bit, MSB first
// -----------------------------------------------------------------------------
module phy_tx_lane
  import phy_tx_serializer_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       boundary,
  input  logic       take,
  input  logic [7:0] data,
  output logic       out
);

  logic [7:0] sr_reg;
  logic [7:0] sr_next;

  always_comb begin
    sr_next = sr_reg;
    if (advance) begin
      if (boundary) begin
        sr_next = take ? data : COMMA;
      end else begin
        sr_next = {sr_reg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg <= COMMA;
    end else begin
      sr_reg <= sr_next;
    end
  end

  assign out = sr_reg[7];

endmodule

// File: rtl/phy_tx_serializer.sv
// -----------------------------------------------------------------------------
// phy_tx_serializer
// Two-lane byte-to-bit serializer. After reset it sends PREAMBLE_WORDS comma
// words on both lanes, then accepts one byte per lane per word slot. Lanes
// share one bit counter so their words stay aligned.
// Ports:
//   clk_8f     - bit-rate clock
//   reset      - asynchronous active-high reset
//   enable     - 1 = advance serialization, 0 = freeze all state
//   data_in_0/valid_in_0, data_in_1/valid_in_1 - per-lane parallel input
//   ready      - byte-load strobe, common to both lanes
//   out_0/out_1 - serial bits, MSB first
//   tx_active  - high once the preamble has been sent
// -----------------------------------------------------------------------------
module phy_tx_serializer
  import phy_tx_serializer_pkg::*;
#(
  parameter logic [7:0] COMMA          = COMMA_DEFAULT,
  parameter int         PREAMBLE_WORDS = PREAMBLE_WORDS_DEFAULT
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready,
  output logic       out_0,
  output logic       out_1,
  output logic       tx_active
);

  // pre_cnt value during the last preamble word; that word's boundary is the
  // first load slot.
  localparam logic [1:0] PRE_LAST = 2'(PREAMBLE_WORDS - 1);

  tx_state_t  state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [1:0] pre_cnt_reg, pre_cnt_next;
  logic       boundary;
  logic       ready_int;

  logic [7:0]           lane_data  [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_out;

  assign boundary = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_PREAMBLE;
      bit_cnt_reg <= 3'd0;
      pre_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      pre_cnt_reg <= pre_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    pre_cnt_next = pre_cnt_reg;
    ready_int    = 1'b0;
    if (enable) begin
      // 3-bit counter wraps 7 -> 0 naturally at the word boundary.
      bit_cnt_next = bit_cnt_reg + 3'd1;
      if (boundary) begin
        unique case (state_reg)
          ST_PREAMBLE: begin
            if (pre_cnt_reg == PRE_LAST) begin
              ready_int  = 1'b1;
              state_next = ST_ACTIVE;
            end else begin
              pre_cnt_next = pre_cnt_reg + 2'd1;
            end
          end
          ST_ACTIVE: begin
            ready_int = 1'b1;
          end
          default: begin
            state_next = ST_PREAMBLE;
          end
        endcase
      end
    end
  end

  assign lane_data[0]  = data_in_0;
  assign lane_data[1]  = data_in_1;
  assign lane_valid[0] = valid_in_0;
  assign lane_valid[1] = valid_in_1;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      phy_tx_lane #(
        .COMMA(COMMA)
      ) u_lane (
        .clk      (clk_8f),
        .rst      (reset),
        .advance  (enable),
        .boundary (boundary),
        .take     (ready_int & lane_valid[gi]),
        .data     (lane_data[gi]),
        .out      (lane_out[gi])
      );
    end
  endgenerate

  assign out_0     = lane_out[0];
  assign out_1     = lane_out[1];
  assign ready     = ready_int;
  assign tx_active = (state_reg == ST_ACTIVE);

endmodule
